// File: rtl/master_bridge_pkg.sv
// Shared constants and types for the master bridge AXI write path.
package master_bridge_pkg;

  // Default field widths of the AXI write path
  localparam int unsigned MB_ADDR_WIDTH     = 64;
  localparam int unsigned MB_BEAT_SIZE      = 1024;
  localparam int unsigned MB_STROBE_WIDTH   = MB_BEAT_SIZE / 8;
  localparam int unsigned MB_ID_WIDTH       = 10;
  localparam int unsigned MB_LEN_WIDTH      = 8;
  localparam int unsigned MB_QOS_WIDTH      = 4;
  localparam int unsigned MB_REQ_INFO_WIDTH = 17;
  localparam int unsigned MB_REQ_ID_WIDTH   = MB_REQ_INFO_WIDTH - 1;
  localparam int unsigned MB_BUSER_WIDTH    = MB_REQ_ID_WIDTH + MB_QOS_WIDTH;

  localparam int unsigned MB_AW_CHANNEL_WIDTH =
    MB_ID_WIDTH + MB_ADDR_WIDTH + MB_LEN_WIDTH + MB_QOS_WIDTH + MB_REQ_INFO_WIDTH;
  localparam int unsigned MB_W_CHANNEL_WIDTH  = MB_STROBE_WIDTH + MB_BEAT_SIZE;
  localparam int unsigned MB_B_CHANNEL_WIDTH  = MB_ID_WIDTH + 2 + MB_BUSER_WIDTH;

  // AXI encodings
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_128B   = 3'b111;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // AW FIFO entry {AWID, AWADDR, AWLEN, AWQOS, req_info}, LSB offsets
  localparam int unsigned AW_REQ_INFO_LSB = 0;
  localparam int unsigned AW_QOS_LSB      = AW_REQ_INFO_LSB + MB_REQ_INFO_WIDTH;
  localparam int unsigned AW_LEN_LSB      = AW_QOS_LSB + MB_QOS_WIDTH;
  localparam int unsigned AW_ADDR_LSB     = AW_LEN_LSB + MB_LEN_WIDTH;
  localparam int unsigned AW_ID_LSB       = AW_ADDR_LSB + MB_ADDR_WIDTH;

  // W FIFO entry {WSTRB, WDATA}
  localparam int unsigned W_DATA_LSB = 0;
  localparam int unsigned W_STRB_LSB = MB_BEAT_SIZE;

  // B FIFO entry {BID, BRESP, BUSER}
  localparam int unsigned B_BUSER_LSB = 0;
  localparam int unsigned B_RESP_LSB  = MB_BUSER_WIDTH;
  localparam int unsigned B_ID_LSB    = B_RESP_LSB + 2;

  // Write engine states
  typedef enum logic [2:0] {
    WR_IDLE,
    WR_AW,
    WR_W,
    WR_B,
    WR_PUSH
  } wr_state_e;

endpackage

// File: rtl/master_bridge_axi_write_ctrl.sv
// AXI4 write master: pops AW/W FIFO entries, runs one AXI write at a time,
// and pushes the tagged B response into the B FIFO.
module master_bridge_axi_write_ctrl
  import master_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = MB_ADDR_WIDTH,
  parameter int unsigned BEAT_SIZE        = MB_BEAT_SIZE,
  parameter int unsigned STROBE_WIDTH     = MB_STROBE_WIDTH,
  parameter int unsigned ID_WIDTH         = MB_ID_WIDTH,
  parameter int unsigned LEN_WIDTH        = MB_LEN_WIDTH,
  parameter int unsigned QOS_WIDTH        = MB_QOS_WIDTH,
  parameter int unsigned REQ_INFO_WIDTH   = MB_REQ_INFO_WIDTH,
  parameter int unsigned AW_CHANNEL_WIDTH = MB_AW_CHANNEL_WIDTH,
  parameter int unsigned W_CHANNEL_WIDTH  = MB_W_CHANNEL_WIDTH,
  parameter int unsigned B_CHANNEL_WIDTH  = MB_B_CHANNEL_WIDTH
) (
  input  logic                        i_axi_clk,
  input  logic                        i_axi_rst,
  input  logic                        i_AWVALID_fifo,
  input  logic [AW_CHANNEL_WIDTH-1:0] i_AW_CHANNEL_fifo,
  output logic                        o_aw_ch_fifo_read_inc,
  input  logic                        i_WVALID_fifo,
  input  logic [W_CHANNEL_WIDTH-1:0]  i_W_CHANNEL_fifo,
  output logic                        o_w_ch_fifo_read_inc,
  input  logic                        i_BREADY_fifo,
  output logic                        o_b_ch_fifo_write_inc,
  output logic [B_CHANNEL_WIDTH-1:0]  o_B_CHANNEL,
  output logic [ID_WIDTH-1:0]         o_AWID,
  output logic [ADDR_WIDTH-1:0]       o_AWADDR,
  output logic [LEN_WIDTH-1:0]        o_AWLEN,
  output logic [2:0]                  o_AWSIZE,
  output logic [1:0]                  o_AWBURST,
  output logic [QOS_WIDTH-1:0]        o_AWQOS,
  output logic                        o_AWVALID,
  input  logic                        i_AWREADY,
  output logic [BEAT_SIZE-1:0]        o_WDATA,
  output logic [STROBE_WIDTH-1:0]     o_WSTRB,
  output logic                        o_WLAST,
  output logic                        o_WVALID,
  input  logic                        i_WREADY,
  input  logic [ID_WIDTH-1:0]         i_BID,
  input  logic [1:0]                  i_BRESP,
  input  logic                        i_BVALID,
  output logic                        o_BREADY
);

  localparam int unsigned REQ_ID_WIDTH = REQ_INFO_WIDTH - 1;
  localparam int unsigned CNT_WIDTH    = LEN_WIDTH + 1;
  localparam int unsigned QOS_LSB      = REQ_INFO_WIDTH;
  localparam int unsigned LEN_LSB      = QOS_LSB + QOS_WIDTH;
  localparam int unsigned ADDR_LSB     = LEN_LSB + LEN_WIDTH;
  localparam int unsigned ID_LSB       = ADDR_LSB + ADDR_WIDTH;

  wr_state_e                   state_q, state_d;
  logic [CNT_WIDTH-1:0]        beat_cnt_q, beat_cnt_d;
  logic [ID_WIDTH-1:0]         awid_q, awid_d;
  logic [ADDR_WIDTH-1:0]       awaddr_q, awaddr_d;
  logic [LEN_WIDTH-1:0]        awlen_q, awlen_d;
  logic [2:0]                  awsize_q, awsize_d;
  logic [1:0]                  awburst_q, awburst_d;
  logic [QOS_WIDTH-1:0]        awqos_q, awqos_d;
  logic                        awvalid_q, awvalid_d;
  logic [REQ_ID_WIDTH-1:0]     req_id_q, req_id_d;
  logic [BEAT_SIZE-1:0]        wdata_q, wdata_d;
  logic [STROBE_WIDTH-1:0]     wstrb_q, wstrb_d;
  logic                        wlast_q, wlast_d;
  logic                        wvalid_q, wvalid_d;
  logic                        bready_q, bready_d;
  logic [B_CHANNEL_WIDTH-1:0]  b_channel_q, b_channel_d;

  logic                        aw_pop, w_pop, b_push;
  logic                        w_load, w_done;
  logic [1:0]                  bresp_chk;
  logic                        unused_req_type;

  // The request-type bit is not needed on the write path
  assign unused_req_type = i_AW_CHANNEL_fifo[0];

  // The W register refills whenever it is empty or being consumed, capped
  // at AWLEN+1 beats so the FIFO is never over-popped.
  assign w_load = (state_q == WR_W) && (!wvalid_q || i_WREADY) && i_WVALID_fifo &&
                  (beat_cnt_q <= {1'b0, awlen_q});
  assign w_done = (state_q == WR_W) && wvalid_q && i_WREADY && wlast_q;
  assign bresp_chk = (i_BID == awid_q) ? i_BRESP : RESP_SLVERR;

  // State and datapath registers
  always_ff @(posedge i_axi_clk) begin
    if (i_axi_rst) begin
      state_q     <= WR_IDLE;
      beat_cnt_q  <= '0;
      awid_q      <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awsize_q    <= '0;
      awburst_q   <= '0;
      awqos_q     <= '0;
      awvalid_q   <= 1'b0;
      req_id_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wlast_q     <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      b_channel_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      awid_q      <= awid_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      awsize_q    <= awsize_d;
      awburst_q   <= awburst_d;
      awqos_q     <= awqos_d;
      awvalid_q   <= awvalid_d;
      req_id_q    <= req_id_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wlast_q     <= wlast_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      b_channel_q <= b_channel_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_IDLE: if (i_AWVALID_fifo)           state_d = WR_AW;
      WR_AW:   if (awvalid_q && i_AWREADY)   state_d = WR_W;
      WR_W:    if (w_done)                   state_d = WR_B;
      WR_B:    if (i_BVALID && bready_q)     state_d = WR_PUSH;
      WR_PUSH: if (i_BREADY_fifo)            state_d = WR_IDLE;
      default:                               state_d = WR_IDLE;
    endcase
  end

  // Output / datapath next values; FIFO pop/push strobes are combinational
  // so the show-ahead head advances on the same edge that consumes it.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    awid_d      = awid_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    awsize_d    = SIZE_128B;
    awburst_d   = BURST_INCR;
    awqos_d     = awqos_q;
    awvalid_d   = awvalid_q;
    req_id_d    = req_id_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wlast_d     = wlast_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    b_channel_d = b_channel_q;
    aw_pop      = 1'b0;
    w_pop       = 1'b0;
    b_push      = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (i_AWVALID_fifo) begin
          aw_pop    = 1'b1;
          awid_d    = i_AW_CHANNEL_fifo[ID_LSB +: ID_WIDTH];
          awaddr_d  = i_AW_CHANNEL_fifo[ADDR_LSB +: ADDR_WIDTH];
          awlen_d   = i_AW_CHANNEL_fifo[LEN_LSB +: LEN_WIDTH];
          awqos_d   = i_AW_CHANNEL_fifo[QOS_LSB +: QOS_WIDTH];
          req_id_d  = i_AW_CHANNEL_fifo[1 +: REQ_ID_WIDTH];
          awvalid_d = 1'b1;
        end
      end
      WR_AW: begin
        if (i_AWREADY) begin
          awvalid_d  = 1'b0;
          beat_cnt_d = '0;
        end
      end
      WR_W: begin
        if (w_load) begin
          w_pop      = 1'b1;
          wdata_d    = i_W_CHANNEL_fifo[0 +: BEAT_SIZE];
          wstrb_d    = i_W_CHANNEL_fifo[BEAT_SIZE +: STROBE_WIDTH];
          wvalid_d   = 1'b1;
          wlast_d    = (beat_cnt_q == {1'b0, awlen_q});
          beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
        end else if (i_WREADY) begin
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
        end
        if (w_done) bready_d = 1'b1;
      end
      WR_B: begin
        if (i_BVALID && bready_q) begin
          bready_d    = 1'b0;
          b_channel_d = {i_BID, bresp_chk, req_id_q, awqos_q};
        end
      end
      WR_PUSH: b_push = i_BREADY_fifo;
      default: ;
    endcase
  end

  assign o_aw_ch_fifo_read_inc = aw_pop && !i_axi_rst;
  assign o_w_ch_fifo_read_inc  = w_pop && !i_axi_rst;
  assign o_b_ch_fifo_write_inc = b_push && !i_axi_rst;
  assign o_B_CHANNEL = b_channel_q;
  assign o_AWID      = awid_q;
  assign o_AWADDR    = awaddr_q;
  assign o_AWLEN     = awlen_q;
  assign o_AWSIZE    = awsize_q;
  assign o_AWBURST   = awburst_q;
  assign o_AWQOS     = awqos_q;
  assign o_AWVALID   = awvalid_q;
  assign o_WDATA     = wdata_q;
  assign o_WSTRB     = wstrb_q;
  assign o_WLAST     = wlast_q;
  assign o_WVALID    = wvalid_q;
  assign o_BREADY    = bready_q;

endmodule

// File: doc/master_bridge_axi_write_ctrl.md
Name: master_bridge_axi_write_ctrl

Overview:
AXI4 write-path master engine in the AXI clock domain of the master bridge. It pops write requests from the AW-channel FIFO and their data beats from the W-channel FIFO, and drives the AXI AW and W handshakes towards the application slave. It collects the B response and pushes it, tagged with requester information, into the B-channel FIFO for completion generation. One write transaction is in flight at a time.

Parameters:
ADDR_WIDTH, 64, AXI address width
BEAT_SIZE, 1024, WDATA width (32 DW)
STROBE_WIDTH, 128, WSTRB width (BEAT_SIZE/8)
ID_WIDTH, 10, AXI ID width
LEN_WIDTH, 8, AxLEN width
QOS_WIDTH, 4, AxQOS width
REQ_INFO_WIDTH, 17, AW request info field: [16:1] requester ID, [0] request type
AW_CHANNEL_WIDTH, 103, AW FIFO entry {AWID, AWADDR, AWLEN, AWQOS, req_info}, MSB first
W_CHANNEL_WIDTH, 1152, W FIFO entry {WSTRB, WDATA}
B_CHANNEL_WIDTH, 32, B FIFO entry {BID, BRESP, BUSER}; BUSER = {requester ID, AWQOS}

Ports:
i_axi_clk  in  1  AXI-domain clock
i_axi_rst  in  1  synchronous active-high reset
i_AWVALID_fifo  in  1  AW FIFO not empty
i_AW_CHANNEL_fifo  in  AW_CHANNEL_WIDTH  AW FIFO head entry (show-ahead)
o_aw_ch_fifo_read_inc  out  1  AW FIFO pop pulse
i_WVALID_fifo  in  1  W FIFO not empty
i_W_CHANNEL_fifo  in  W_CHANNEL_WIDTH  W FIFO head entry (show-ahead)
o_w_ch_fifo_read_inc  out  1  W FIFO pop pulse
i_BREADY_fifo  in  1  B FIFO not full
o_b_ch_fifo_write_inc  out  1  B FIFO push pulse
o_B_CHANNEL  out  B_CHANNEL_WIDTH  B FIFO write data
o_AWID  out  ID_WIDTH  AXI AWID
o_AWADDR  out  ADDR_WIDTH  AXI AWADDR
o_AWLEN  out  LEN_WIDTH  AXI AWLEN
o_AWSIZE  out  3  constant 3'b111 (128 B)
o_AWBURST  out  2  constant 2'b01 (INCR)
o_AWQOS  out  QOS_WIDTH  AXI AWQOS
o_AWVALID  out  1  AXI AWVALID
i_AWREADY  in  1  AXI AWREADY
o_WDATA  out  BEAT_SIZE  AXI WDATA
o_WSTRB  out  STROBE_WIDTH  AXI WSTRB
o_WLAST  out  1  AXI WLAST
o_WVALID  out  1  AXI WVALID
i_WREADY  in  1  AXI WREADY
i_BID  in  ID_WIDTH  AXI BID
i_BRESP  in  2  AXI BRESP
i_BVALID  in  1  AXI BVALID
o_BREADY  out  1  AXI BREADY

Behaviour:
- All outputs registered. Reset (sync, active-high) forces state IDLE, the beat counter to 0, and every output, including AWSIZE/AWBURST registers, to 0. Constants load on the first post-reset cycle.
- On reset mid-transaction, anything already popped is discarded. No AXI valid stays asserted after the reset cycle.
- FSM states: IDLE -> AW -> W -> B -> PUSH -> IDLE.
- IDLE:
  - If i_AWVALID_fifo=1, latch the head entry into the AW registers and pulse o_aw_ch_fifo_read_inc in that same cycle.
  - Next cycle o_AWVALID=1 and the FSM enters AW. Latency from FIFO non-empty to AWVALID is 1 cycle.
  - Latch requester ID and AWQOS for BUSER.
- AW:
  - Hold o_AWVALID and all AW fields stable until i_AWREADY=1.
  - On handshake, o_AWVALID=0 the next cycle; enter W with beat_cnt=0.
- W (single output register):
  - The register loads when (o_WVALID=0 or i_WREADY=1), i_WVALID_fifo=1, and beats_issued <= AWLEN.
  - On load, pulse o_w_ch_fifo_read_inc and drive o_WLAST = (beats_issued == AWLEN).
  - If the FIFO is empty when the register frees, o_WVALID drops to 0. This gives back-to-back beats at full rate, and the FIFO is never popped beyond AWLEN+1 beats.
  - On the handshake of the WLAST beat, o_WVALID=0, o_WLAST=0, o_BREADY=1; enter B.
- B:
  - On i_BVALID & o_BREADY, capture BID and BRESP; o_BREADY=0; enter PUSH.
  - If captured BID != latched AWID, store BRESP as 2'b10 (SLVERR).
- PUSH:
  - Drive o_B_CHANNEL = {BID, BRESP, requester ID, AWQOS}.
  - When i_BREADY_fifo=1, pulse o_b_ch_fifo_write_inc for exactly 1 cycle, then go to IDLE.
  - While the FIFO is full, wait with o_B_CHANNEL held.
- Handshake rules:
  - Once asserted, o_AWVALID/o_WVALID never deassert before their handshake.
  - The module never waits for READY before asserting VALID.
  - BVALID arriving before BREADY is held by the slave.
- AWLEN=0: a single beat with WLAST=1.
- AWLEN=255: beat_cnt is 9 bits, so there is no wrap.
- An AW FIFO entry arriving during W/B/PUSH is ignored until IDLE.

Decomposition:
- Package master_bridge_pkg holds:
  - field widths (ID, LEN, QOS, REQ_INFO, BUSER);
  - AXI encodings BURST_INCR=2'b01, SIZE_128B=3'b111, RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - the write-FSM state enum;
  - AW/W/B entry slice offsets.
- No sub-module is needed. FSM, W output register and B capture fit in one module.

Test Plan:
- AW entry {AWID=10'h05, AWADDR=64'h1000, AWLEN=0} and one W beat, AWREADY/WREADY tied 1, BVALID with BID=5/BRESP=0 -> AWVALID 1 cycle after pop, single beat with WLAST=1, B FIFO push {5, 2'b00, req_id, qos}, exactly one pop per FIFO.
- AWLEN=3, W FIFO preloaded with 4 beats, WREADY=1 -> 4 consecutive WVALID cycles, WLAST on the 4th only, exactly 4 W pops.
- AWLEN=3, WREADY toggling 1/0 and W FIFO empty for 2 cycles mid-burst -> WDATA/WSTRB stable while stalled, beat order preserved, no extra pop.
- BID=7 while AWID=5, BRESP=00 -> pushed BRESP=2'b10.
- i_BREADY_fifo=0 for 5 cycles in PUSH -> o_B_CHANNEL held, single push pulse on release.
- i_axi_rst asserted during W beat 2 of AWLEN=7 -> next cycle all valids 0, state IDLE; the next AW entry runs normally.
